// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared types and constants for the core_ctrl sequencer.
//   state_e       - sequencer state encoding
//   dec_e         - result of classifying the instruction held in IR
//   OPC_*, F3_*   - opcode / funct3 values the sequencer recognises
//   ERR_*         - halt cause codes reported on err
//   classify()    - maps (opcode, funct3) to a dec_e
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_DECODE   = 3'd3,
        ST_EXEC     = 3'd4,
        ST_HALT     = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        DEC_EXEC    = 2'd0,
        DEC_EBREAK  = 2'd1,
        DEC_ILLEGAL = 2'd2
    } dec_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [2:0] F3_EBREAK  = 3'b000;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Only OP-IMM executes; SYSTEM/funct3=000 stops cleanly, all else is illegal.
    function automatic dec_e classify(input logic [6:0] opcode, input logic [2:0] funct3);
        dec_e res;
        case (opcode)
            OPC_OP_IMM: res = DEC_EXEC;
            OPC_SYSTEM: res = (funct3 == F3_EBREAK) ? DEC_EBREAK : DEC_ILLEGAL;
            default:    res = DEC_ILLEGAL;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/core_ctrl_if.sv
// core_ctrl_if: instruction-fetch handshake between the sequencer and memory.
//   imem_req_valid - fetch request for the address on PC (sequencer -> memory)
//   imem_req_ready - memory accepts the request           (memory -> sequencer)
//   imem_rsp_valid - instruction word valid on datapath   (memory -> sequencer)
// Modports: master = sequencer side, slave = memory side.
interface core_ctrl_if;
    logic imem_req_valid;
    logic imem_req_ready;
    logic imem_rsp_valid;

    modport master (output imem_req_valid, input  imem_req_ready, input  imem_rsp_valid);
    modport slave  (input  imem_req_valid, output imem_req_ready, output imem_rsp_valid);
endinterface

// File: rtl/core_ctrl_perf.sv
// core_ctrl_perf: free-running performance counters, wrapping silently.
//   clk, rst     - clock, asynchronous active-low reset
//   retire       - one instruction completes this cycle
//   run          - sequencer is actively working (not IDLE, not HALT)
//   cycle_cnt    - number of run cycles since reset release
//   instret_cnt  - number of retired instructions
module core_ctrl_perf #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire,
    input  logic             run,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

    // Counter next values.
    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (run) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end
        if (retire) begin
            instret_cnt_d = instret_cnt_q + CNT_W'(1);
        end else begin
            instret_cnt_d = instret_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q   <= {CNT_W{1'b0}};
            instret_cnt_q <= {CNT_W{1'b0}};
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle control sequencer for the RV32 datapath.
// Walks FETCH -> WAIT_RSP -> DECODE -> EXEC per instruction and gates IR load,
// PC advance and register-file write so each happens once per instruction.
// Stops in HALT on EBREAK, illegal opcode or fetch timeout.
//   clk, rst            - clock, asynchronous active-low reset
//   imem (master)       - fetch handshake (req_valid/req_ready/rsp_valid)
//   opcode, funct3      - fields of the instruction currently held in IR
//   ir_en, pc_en, rf_wen- datapath update strobes for this edge
//   halt, err           - sticky stop flag and its cause
//   cycle_cnt, instret_cnt - performance counters
// Build option: CORE_CTRL_PERF_EN enables the counters; without it they read 0.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    core_ctrl_if.master      imem,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    output logic             ir_en,
    output logic             pc_en,
    output logic             rf_wen,
    output logic             halt,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    // The last WAIT_RSP cycle before giving up has a count of TIMEOUT_CYCLES-1.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        halt_q, halt_d;
    logic [1:0]  err_q, err_d;

    // State, timeout counter and halt-cause registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 16'd0;
            halt_q     <= 1'b0;
            err_q      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            halt_q     <= halt_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic; halt/err are decided together with the HALT transition.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        halt_d     = halt_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_req_ready) begin
                    state_d    = ST_WAIT_RSP;
                    wait_cnt_d = 16'd0;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WAIT_RSP: begin
                // A response arriving on the limit cycle still wins.
                if (imem.imem_rsp_valid) begin
                    state_d = ST_DECODE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_HALT;
                    halt_d  = 1'b1;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ST_DECODE: begin
                case (classify(opcode, funct3))
                    DEC_EXEC: begin
                        state_d = ST_EXEC;
                    end
                    DEC_EBREAK: begin
                        state_d = ST_HALT;
                        halt_d  = 1'b1;
                        err_d   = ERR_NONE;
                    end
                    default: begin
                        state_d = ST_HALT;
                        halt_d  = 1'b1;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: Moore strobes, ir_en qualified by the response handshake.
    always_comb begin
        imem.imem_req_valid = 1'b0;
        ir_en               = 1'b0;
        pc_en               = 1'b0;
        rf_wen              = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem.imem_req_valid = 1'b1;
            end
            ST_WAIT_RSP: begin
                ir_en = imem.imem_rsp_valid;
            end
            ST_EXEC: begin
                pc_en  = 1'b1;
                rf_wen = 1'b1;
            end
            default: begin
                imem.imem_req_valid = 1'b0;
            end
        endcase
    end

    assign halt = halt_q;
    assign err  = err_q;

`ifdef CORE_CTRL_PERF_EN
    logic retire_s;
    logic run_s;

    assign retire_s = (state_q == ST_EXEC);
    assign run_s    = (state_q != ST_IDLE) && (state_q != ST_HALT);

    core_ctrl_perf #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk        (clk),
        .rst        (rst),
        .retire     (retire_s),
        .run        (run_s),
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
    );
`else
    assign cycle_cnt   = {CNT_W{1'b0}};
    assign instret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed self-checking bench for core_ctrl.
// A small memory model answers fetches with configurable ready stall and
// response delay; a bench-side PC/IR model feeds opcode/funct3.
module tb_core_ctrl;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_SYS  = 7'b1110011;
    localparam logic [6:0] OP_REG  = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        ir_en, pc_en, rf_wen, halt;
    logic [1:0]  err;
    logic [31:0] cycle_cnt, instret_cnt;

    core_ctrl_if imem_if ();

    core_ctrl #(
        .TIMEOUT_CYCLES(8),
        .CNT_W         (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem       (imem_if),
        .opcode     (opcode),
        .funct3     (funct3),
        .ir_en      (ir_en),
        .pc_en      (pc_en),
        .rf_wen     (rf_wen),
        .halt       (halt),
        .err        (err),
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Bench-side datapath / memory model state.
    logic [31:0] pc;
    logic [6:0]  prog_op [8];
    logic [2:0]  prog_f3 [8];
    bit          pending;
    int          elapsed, rsp_delay, ready_low_left;
    bit          spur;
    int          n_req, n_ir, n_pc, n_rf, overlap, ticks;
    bit          s_req, s_halt;
    logic [1:0]  s_err;
    logic [31:0] s_cyc, s_ins;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pexp(input logic [31:0] v);
`ifdef CORE_CTRL_PERF_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    // One clock cycle: drive at negedge, sample, then update models after posedge.
    task automatic tick();
        bit s_ir, s_pc, s_rf, s_rdy, s_rsp;
        int idx;
        imem_if.imem_req_ready = (ready_low_left == 0);
        imem_if.imem_rsp_valid = (pending && rsp_delay >= 0 && elapsed == rsp_delay) ||
                                 (spur && !pending && imem_if.imem_req_valid);
        #1;
        s_req  = imem_if.imem_req_valid;
        s_rdy  = imem_if.imem_req_ready;
        s_rsp  = imem_if.imem_rsp_valid;
        s_ir   = ir_en;
        s_pc   = pc_en;
        s_rf   = rf_wen;
        s_halt = halt;
        s_err  = err;
        s_cyc  = cycle_cnt;
        s_ins  = instret_cnt;
        if ((int'(s_ir) + int'(s_pc) + int'(s_req) > 1) || (s_rf != s_pc)) overlap++;
        if (s_req) n_req++;
        if (s_ir) n_ir++;
        if (s_pc) n_pc++;
        if (s_rf) n_rf++;
        ticks++;
        @(posedge clk);
        #1;
        if (s_ir) begin
            idx    = int'((pc - 32'h8000_0000) >> 2) & 7;
            opcode = prog_op[idx];
            funct3 = prog_f3[idx];
        end
        if (s_pc) pc = pc + 32'd4;
        if (s_req && s_rdy) begin
            pending = 1'b1;
            elapsed = 0;
        end else if (pending) begin
            if (s_rsp) pending = 1'b0;
            else elapsed++;
        end
        if (s_req && !s_rdy && ready_low_left > 0) ready_low_left--;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        imem_if.imem_req_ready = 1'b0;
        imem_if.imem_rsp_valid = 1'b0;
        opcode = 7'd0;
        funct3 = 3'd0;
        #1;
        check_val("rst_outs", {imem_if.imem_req_valid, ir_en, pc_en, rf_wen, halt, err}, 64'd0);
        check_val("rst_cnts", {cycle_cnt, instret_cnt}, 64'd0);
        repeat (2) @(negedge clk);
        pc = 32'h8000_0000;
        pending = 1'b0; elapsed = 0; rsp_delay = 0; ready_low_left = 0; spur = 1'b0;
        n_req = 0; n_ir = 0; n_pc = 0; n_rf = 0; overlap = 0; ticks = 0;
        s_halt = 1'b0; s_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            prog_op[i] = OP_SYS;
            prog_f3[i] = 3'b000;
        end
        rst = 1'b1;
    endtask

    task automatic run_to_halt(input string tag, input int limit);
        while (!s_halt && ticks < limit) tick();
        check_val({tag, "_halted"}, 64'(s_halt), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        do_reset();

        // Zero-wait: 3 ADDI then EBREAK.
        for (int i = 0; i < 3; i++) prog_op[i] = OP_ADDI;
        tick();
        check_val("idle_no_req", 64'(s_req), 64'd0);
        tick();
        check_val("first_req", 64'(s_req), 64'd1);
        run_to_halt("prog", 60);
        check_val("prog_halt_tick", 64'(ticks), 64'd17);
        check_val("prog_err", 64'(s_err), 64'd0);
        check_val("prog_pc_en", 64'(n_pc), 64'd3);
        check_val("prog_rf_wen", 64'(n_rf), 64'd3);
        check_val("prog_ir_en", 64'(n_ir), 64'd4);
        check_val("prog_pc", 64'(pc), 64'h8000_000C);
        check_val("prog_instret", 64'(s_ins), 64'(pexp(32'd3)));
        check_val("prog_cycles", 64'(s_cyc), 64'(pexp(32'd15)));
        repeat (5) tick();
        check_val("halt_sticky", {62'(s_halt), s_err}, {62'd1, 2'b00});
        check_val("halt_frozen", {s_cyc, s_ins}, {pexp(32'd15), pexp(32'd3)});
        check_val("halt_no_en", 64'(n_pc + n_rf + n_ir + n_req), 64'd14);
        check_val("prog_overlap", 64'(overlap), 64'd0);

        // Ready held low 5 cycles, spurious response during FETCH.
        do_reset();
        ready_low_left = 5;
        spur = 1'b1;
        run_to_halt("stall", 60);
        check_val("stall_req_cycles", 64'(n_req), 64'd6);
        check_val("stall_ir_en", 64'(n_ir), 64'd1);
        check_val("stall_pc_rf", 64'(n_pc + n_rf), 64'd0);
        check_val("stall_halt_tick", 64'(ticks), 64'd10);
        check_val("stall_err", 64'(s_err), 64'd0);
        check_val("stall_cycles", 64'(s_cyc), 64'(pexp(32'd8)));

        // No response: timeout after 8 WAIT_RSP cycles.
        do_reset();
        rsp_delay = -1;
        run_to_halt("tmo", 60);
        check_val("tmo_halt_tick", 64'(ticks), 64'd11);
        check_val("tmo_err", 64'(s_err), 64'd2);
        check_val("tmo_ir_en", 64'(n_ir), 64'd0);
        check_val("tmo_pc_rf", 64'(n_pc + n_rf), 64'd0);
        check_val("tmo_cycles", 64'(s_cyc), 64'(pexp(32'd9)));

        // Response on the limit cycle wins.
        do_reset();
        rsp_delay = 7;
        prog_op[0] = OP_ADDI;
        run_to_halt("edge", 80);
        check_val("edge_halt_tick", 64'(ticks), 64'd23);
        check_val("edge_err", 64'(s_err), 64'd0);
        check_val("edge_pc_en", 64'(n_pc), 64'd1);
        check_val("edge_instret", 64'(s_ins), 64'(pexp(32'd1)));
        check_val("edge_cycles", 64'(s_cyc), 64'(pexp(32'd21)));

        // Illegal R-type after one ADDI.
        do_reset();
        prog_op[0] = OP_ADDI;
        prog_op[1] = OP_REG;
        run_to_halt("ill", 60);
        check_val("ill_halt_tick", 64'(ticks), 64'd9);
        check_val("ill_err", 64'(s_err), 64'd1);
        check_val("ill_pc_rf", {32'(n_pc), 32'(n_rf)}, {32'd1, 32'd1});
        check_val("ill_pc", 64'(pc), 64'h8000_0004);
        check_val("ill_instret", 64'(s_ins), 64'(pexp(32'd1)));

        // SYSTEM with non-zero funct3 is illegal.
        do_reset();
        prog_f3[0] = 3'b001;
        run_to_halt("sys", 60);
        check_val("sys_halt_tick", 64'(ticks), 64'd5);
        check_val("sys_err", 64'(s_err), 64'd1);
        check_val("sys_pc_en", 64'(n_pc), 64'd0);

        // Asynchronous reset in the middle of WAIT_RSP.
        do_reset();
        prog_op[0] = OP_ADDI;
        rsp_delay = -1;
        repeat (3) tick();
        #3;
        do_reset();
        tick();
        check_val("rrst_idle", {32'(s_req), s_cyc, s_ins} , 96'd0);
        tick();
        check_val("rrst_req", 64'(s_req), 64'd1);
        check_val("rrst_pc", 64'(pc), 64'h8000_0000);
        run_to_halt("rrst", 60);
        check_val("rrst_err", 64'(s_err), 64'd0);
        check_val("rrst_pc_en", 64'(n_pc), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
